// File: rtl/instruction_decode_pkg.sv
// Shared RV32I decode types: instruction layout, ALU/write-back selectors,
// opcode constants, the ID/EX register bundle and immediate/ALU helper functions.
package instruction_decode_pkg;

   typedef logic [31:0] dataBus_t;
   typedef logic [4:0]  regAddr_t;

   typedef struct packed {
      logic [6:0] funct7;
      regAddr_t   rs2;
      regAddr_t   rs1;
      logic [2:0] funct3;
      regAddr_t   rd;
      logic [6:0] opcode;
   } instFields_t;

   typedef union packed {
      logic [31:0] raw;
      instFields_t f;
   } instruction_u;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_COPY2 = 4'd10
   } aluOp_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wbSel_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } immFmt_e;

   typedef struct packed {
      dataBus_t   pc;
      dataBus_t   rs1_data;
      dataBus_t   rs2_data;
      dataBus_t   imm;
      regAddr_t   rs1;
      regAddr_t   rs2;
      regAddr_t   rd;
      logic [2:0] funct3;
      aluOp_e     alu_op;
      logic       alu_src1;
      logic       alu_src2;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      wbSel_e     wb_sel;
      logic       branch;
      logic       jump;
      logic       trap;
   } idex_t;

   function automatic dataBus_t gen_imm(input immFmt_e fmt, input logic [31:0] i);
      dataBus_t imm;
      case (fmt)
         IMM_I:   imm = {{20{i[31]}}, i[31:20]};
         IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   imm = {i[31:12], 12'b0};
         IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // alt selects SUB (funct3 000) or SRA (funct3 101); callers decide when it applies.
   function automatic aluOp_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      aluOp_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 2-read/1-write register file with x0 hard-wired to zero and
// same-cycle write-through to both read ports.
module register_file
   import instruction_decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(NREGS)-1:0] wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic [$clog2(NREGS)-1:0] rd_addr_a,
   input  logic [$clog2(NREGS)-1:0] rd_addr_b,
   output logic [XLEN-1:0]          rd_data_a,
   output logic [XLEN-1:0]          rd_data_b
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_live;

   assign wr_live = wr_en && (wr_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_a = regs[rd_addr_a];
      rd_data_b = regs[rd_addr_b];
      if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      if (rd_addr_a == AW'(0)) rd_data_a = '0;
      if (rd_addr_b == AW'(0)) rd_data_b = '0;
   end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: opcode decode, immediate generation, register read,
// load-use stall detection and the ID/EX pipeline register.
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  instruction_u    inst_id,
   input  dataBus_t        pc_id,
   input  logic            flush,
   input  logic            reg_wr_wb,
   input  regAddr_t        rd_wb,
   input  logic [XLEN-1:0] rd_data_wb,
   output logic            stall_id,
   output logic [XLEN-1:0] pc_ex,
   output logic [XLEN-1:0] rs1_data_ex,
   output logic [XLEN-1:0] rs2_data_ex,
   output logic [XLEN-1:0] imm_ex,
   output regAddr_t        rs1_ex,
   output regAddr_t        rs2_ex,
   output regAddr_t        rd_ex,
   output logic [2:0]      funct3_ex,
   output aluOp_e          alu_op_ex,
   output logic            alu_src1_ex,
   output logic            alu_src2_ex,
   output logic            mem_rd_ex,
   output logic            mem_wr_ex,
   output logic            reg_wr_ex,
   output wbSel_e          wb_sel_ex,
   output logic            branch_ex,
   output logic            jump_ex,
   output logic            trap_ex
);

   idex_t      idex;
   idex_t      nxt;
   immFmt_e    fmt;
   logic       use1, use2, illegal;
   aluOp_e     alu_op;
   logic       src1, src2, mem_rd, mem_wr, reg_wr, branch, jump;
   wbSel_e     wb_sel;
   regAddr_t   rs1_addr, rs2_addr;
   dataBus_t   rs1_data, rs2_data;
   logic [6:0] op, f7;
   logic [2:0] f3;

   assign op = inst_id.f.opcode;
   assign f3 = inst_id.f.funct3;
   assign f7 = inst_id.f.funct7;

   always_comb begin
      fmt     = IMM_NONE;
      use1    = 1'b0;
      use2    = 1'b0;
      illegal = 1'b0;
      alu_op  = ALU_ADD;
      src1    = 1'b0;
      src2    = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      reg_wr  = 1'b0;
      wb_sel  = WB_ALU;
      branch  = 1'b0;
      jump    = 1'b0;
      case (op)
         OPC_LUI: begin
            fmt = IMM_U; alu_op = ALU_COPY2; src2 = 1'b1; reg_wr = 1'b1;
         end
         OPC_AUIPC: begin
            fmt = IMM_U; src1 = 1'b1; src2 = 1'b1; reg_wr = 1'b1;
         end
         OPC_JAL: begin
            fmt = IMM_J; src1 = 1'b1; src2 = 1'b1; jump = 1'b1; reg_wr = 1'b1; wb_sel = WB_PC4;
         end
         OPC_JALR: begin
            fmt = IMM_I; use1 = 1'b1; src2 = 1'b1; jump = 1'b1; reg_wr = 1'b1; wb_sel = WB_PC4;
         end
         OPC_BRANCH: begin
            fmt = IMM_B; use1 = 1'b1; use2 = 1'b1; branch = 1'b1;
            case (f3)
               3'b000, 3'b001: alu_op = ALU_SUB;
               3'b100, 3'b101: alu_op = ALU_SLT;
               3'b110, 3'b111: alu_op = ALU_SLTU;
               default:        illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            fmt = IMM_I; use1 = 1'b1; src2 = 1'b1; mem_rd = 1'b1; reg_wr = 1'b1; wb_sel = WB_MEM;
         end
         OPC_STORE: begin
            fmt = IMM_S; use1 = 1'b1; use2 = 1'b1; src2 = 1'b1; mem_wr = 1'b1;
         end
         OPC_OP_IMM: begin
            fmt = IMM_I; use1 = 1'b1; src2 = 1'b1; reg_wr = 1'b1;
            // Only shifts carry a funct7 field; for ADDI bit 30 is plain immediate.
            alu_op = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
            if ((f3 == 3'b001) && (f7 != 7'b0000000)) illegal = 1'b1;
            if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000)) illegal = 1'b1;
         end
         OPC_OP: begin
            use1 = 1'b1; use2 = 1'b1; reg_wr = 1'b1;
            alu_op = alu_from_funct3(f3, f7[5]);
            if (!((f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))))
               illegal = 1'b1;
         end
         OPC_MISC_MEM: begin
         end
         OPC_SYSTEM: illegal = 1'b1;
         default:    illegal = (inst_id.raw != 32'h0);
      endcase
      if (illegal) begin
         fmt    = IMM_NONE;
         use1   = 1'b0;
         use2   = 1'b0;
         alu_op = ALU_ADD;
         src1   = 1'b0;
         src2   = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         reg_wr = 1'b0;
         wb_sel = WB_ALU;
         branch = 1'b0;
         jump   = 1'b0;
      end
   end

   assign rs1_addr = use1 ? inst_id.f.rs1 : '0;
   assign rs2_addr = use2 ? inst_id.f.rs2 : '0;

   register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_register_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (clk_en && reg_wr_wb),
      .wr_addr   (rd_wb),
      .wr_data   (rd_data_wb),
      .rd_addr_a (rs1_addr),
      .rd_addr_b (rs2_addr),
      .rd_data_a (rs1_data),
      .rd_data_b (rs2_data)
   );

   always_comb begin
      nxt          = '0;
      nxt.pc       = pc_id;
      nxt.rs1_data = rs1_data;
      nxt.rs2_data = rs2_data;
      nxt.imm      = gen_imm(fmt, inst_id.raw);
      nxt.rs1      = rs1_addr;
      nxt.rs2      = rs2_addr;
      nxt.rd       = reg_wr ? inst_id.f.rd : '0;
      nxt.funct3   = f3;
      nxt.alu_op   = alu_op;
      nxt.alu_src1 = src1;
      nxt.alu_src2 = src2;
      nxt.mem_rd   = mem_rd;
      nxt.mem_wr   = mem_wr;
      nxt.reg_wr   = reg_wr;
      nxt.wb_sel   = wb_sel;
      nxt.branch   = branch;
      nxt.jump     = jump;
      nxt.trap     = illegal;
   end

   assign stall_id = !flush && idex.mem_rd && (idex.rd != '0) &&
                     ((use1 && (idex.rd == inst_id.f.rs1)) ||
                      (use2 && (idex.rd == inst_id.f.rs2)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex <= '0;
      end else if (clk_en) begin
         if (flush || stall_id) idex <= '0;
         else                   idex <= nxt;
      end
   end

   assign pc_ex       = idex.pc;
   assign rs1_data_ex = idex.rs1_data;
   assign rs2_data_ex = idex.rs2_data;
   assign imm_ex      = idex.imm;
   assign rs1_ex      = idex.rs1;
   assign rs2_ex      = idex.rs2;
   assign rd_ex       = idex.rd;
   assign funct3_ex   = idex.funct3;
   assign alu_op_ex   = idex.alu_op;
   assign alu_src1_ex = idex.alu_src1;
   assign alu_src2_ex = idex.alu_src2;
   assign mem_rd_ex   = idex.mem_rd;
   assign mem_wr_ex   = idex.mem_wr;
   assign reg_wr_ex   = idex.reg_wr;
   assign wb_sel_ex   = idex.wb_sel;
   assign branch_ex   = idex.branch;
   assign jump_ex     = idex.jump;
   assign trap_ex     = idex.trap;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with hand-computed encodings and results.
module tb_instruction_decode;
   import instruction_decode_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clk_en;
   instruction_u inst_id;
   dataBus_t     pc_id;
   logic         flush;
   logic         reg_wr_wb;
   regAddr_t     rd_wb;
   logic [31:0]  rd_data_wb;
   logic         stall_id;
   logic [31:0]  pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
   regAddr_t     rs1_ex, rs2_ex, rd_ex;
   logic [2:0]   funct3_ex;
   aluOp_e       alu_op_ex;
   logic         alu_src1_ex, alu_src2_ex, mem_rd_ex, mem_wr_ex, reg_wr_ex;
   wbSel_e       wb_sel_ex;
   logic         branch_ex, jump_ex, trap_ex;

   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;

   instruction_decode #(.XLEN(32), .NREGS(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .inst_id     (inst_id),
      .pc_id       (pc_id),
      .flush       (flush),
      .reg_wr_wb   (reg_wr_wb),
      .rd_wb       (rd_wb),
      .rd_data_wb  (rd_data_wb),
      .stall_id    (stall_id),
      .pc_ex       (pc_ex),
      .rs1_data_ex (rs1_data_ex),
      .rs2_data_ex (rs2_data_ex),
      .imm_ex      (imm_ex),
      .rs1_ex      (rs1_ex),
      .rs2_ex      (rs2_ex),
      .rd_ex       (rd_ex),
      .funct3_ex   (funct3_ex),
      .alu_op_ex   (alu_op_ex),
      .alu_src1_ex (alu_src1_ex),
      .alu_src2_ex (alu_src2_ex),
      .mem_rd_ex   (mem_rd_ex),
      .mem_wr_ex   (mem_wr_ex),
      .reg_wr_ex   (reg_wr_ex),
      .wb_sel_ex   (wb_sel_ex),
      .branch_ex   (branch_ex),
      .jump_ex     (jump_ex),
      .trap_ex     (trap_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      clk_en     = 1'b1;
      inst_id    = '0;
      pc_id      = 32'h0;
      flush      = 1'b0;
      reg_wr_wb  = 1'b0;
      rd_wb      = '0;
      rd_data_wb = '0;
      #12;
      chk("rst_pc",     pc_ex, 32'h0);
      chk("rst_regwr",  32'(reg_wr_ex), 32'h0);
      chk("rst_trap",   32'(trap_ex), 32'h0);
      chk("rst_stall",  32'(stall_id), 32'h0);
      chk("rst_rd",     32'(rd_ex), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // addi x1,x0,5
      inst_id.raw = 32'h00500093; pc_id = 32'h40;
      tick();
      chk("addi_regwr", 32'(reg_wr_ex), 32'h1);
      chk("addi_rd",    32'(rd_ex), 32'h1);
      chk("addi_imm",   imm_ex, 32'h5);
      chk("addi_alu",   32'(alu_op_ex), 32'(ALU_ADD));
      chk("addi_src2",  32'(alu_src2_ex), 32'h1);
      chk("addi_trap",  32'(trap_ex), 32'h0);
      chk("addi_pc",    pc_ex, 32'h40);

      // write-back x2 while decoding add x3,x2,x2
      reg_wr_wb = 1'b1; rd_wb = 5'd2; rd_data_wb = 32'hDEADBEEF;
      inst_id.raw = 32'h002101B3;
      tick();
      reg_wr_wb = 1'b0;
      chk("wt_rs1",  rs1_data_ex, 32'hDEADBEEF);
      chk("wt_rs2",  rs2_data_ex, 32'hDEADBEEF);
      chk("add_rd",  32'(rd_ex), 32'h3);
      chk("add_src2", 32'(alu_src2_ex), 32'h0);
      chk("add_imm", imm_ex, 32'h0);

      // lw x5,0(x0)
      inst_id.raw = 32'h00002283;
      tick();
      chk("lw_memrd", 32'(mem_rd_ex), 32'h1);
      chk("lw_rd",    32'(rd_ex), 32'h5);
      chk("lw_wb",    32'(wb_sel_ex), 32'(WB_MEM));

      // add x6,x5,x1 behind the load
      inst_id.raw = 32'h00128333;
      flush = 1'b1;
      #1;
      chk("stall_flush", 32'(stall_id), 32'h0);
      flush = 1'b0;
      #1;
      chk("stall_hi", 32'(stall_id), 32'h1);
      tick();
      chk("bub_memrd", 32'(mem_rd_ex), 32'h0);
      chk("bub_regwr", 32'(reg_wr_ex), 32'h0);
      chk("bub_rd",    32'(rd_ex), 32'h0);
      chk("bub_pc",    pc_ex, 32'h0);
      chk("stall_lo",  32'(stall_id), 32'h0);
      tick();
      chk("iss_rd",    32'(rd_ex), 32'h6);
      chk("iss_rs1",   32'(rs1_ex), 32'h5);
      chk("iss_rs2",   32'(rs2_ex), 32'h1);
      chk("iss_regwr", 32'(reg_wr_ex), 32'h1);

      // beq x0,x0,-4
      inst_id.raw = 32'hFE000EE3; pc_id = 32'h100;
      tick();
      chk("beq_branch", 32'(branch_ex), 32'h1);
      chk("beq_imm",    imm_ex, 32'hFFFFFFFC);
      chk("beq_rd",     32'(rd_ex), 32'h0);
      chk("beq_regwr",  32'(reg_wr_ex), 32'h0);
      chk("beq_alu",    32'(alu_op_ex), 32'(ALU_SUB));
      chk("beq_pc",     pc_ex, 32'h100);

      // sw x2,4(x1)
      inst_id.raw = 32'h0020A223;
      tick();
      chk("sw_memwr", 32'(mem_wr_ex), 32'h1);
      chk("sw_rd",    32'(rd_ex), 32'h0);
      chk("sw_imm",   imm_ex, 32'h4);
      chk("sw_rs2d",  rs2_data_ex, 32'hDEADBEEF);

      // jal x1,8
      inst_id.raw = 32'h008000EF;
      tick();
      chk("jal_jump", 32'(jump_ex), 32'h1);
      chk("jal_imm",  imm_ex, 32'h8);
      chk("jal_wb",   32'(wb_sel_ex), 32'(WB_PC4));
      chk("jal_src1", 32'(alu_src1_ex), 32'h1);

      // flush over addi, with a write-back to x7 that must still land
      inst_id.raw = 32'h00500093; flush = 1'b1;
      reg_wr_wb = 1'b1; rd_wb = 5'd7; rd_data_wb = 32'h55;
      tick();
      flush = 1'b0; reg_wr_wb = 1'b0;
      chk("fl_regwr", 32'(reg_wr_ex), 32'h0);
      chk("fl_src2",  32'(alu_src2_ex), 32'h0);
      chk("fl_imm",   imm_ex, 32'h0);
      chk("fl_rd",    32'(rd_ex), 32'h0);
      inst_id.raw = 32'h00038433; // add x8,x7,x0
      tick();
      chk("fl_wb_x7", rs1_data_ex, 32'h55);

      inst_id.raw = 32'h00000000;
      tick();
      chk("nop_trap",  32'(trap_ex), 32'h0);
      chk("nop_regwr", 32'(reg_wr_ex), 32'h0);
      chk("nop_memwr", 32'(mem_wr_ex), 32'h0);

      inst_id.raw = 32'hFFFFFFFF;
      tick();
      chk("ill_trap",  32'(trap_ex), 32'h1);
      chk("ill_regwr", 32'(reg_wr_ex), 32'h0);
      chk("ill_memwr", 32'(mem_wr_ex), 32'h0);
      chk("ill_memrd", 32'(mem_rd_ex), 32'h0);

      // write x0 while reading it via add x9,x0,x0
      reg_wr_wb = 1'b1; rd_wb = 5'd0; rd_data_wb = 32'h1234;
      inst_id.raw = 32'h000004B3;
      tick();
      reg_wr_wb = 1'b0;
      chk("x0_wt",  rs1_data_ex, 32'h0);
      tick();
      chk("x0_rd",  rs1_data_ex, 32'h0);
      chk("x0_rd9", 32'(rd_ex), 32'h9);

      // clock enable low for three edges during a write to x11
      clk_en = 1'b0;
      reg_wr_wb = 1'b1; rd_wb = 5'd11; rd_data_wb = 32'hAAAA;
      inst_id.raw = 32'h00500093;
      tick(); tick(); tick();
      chk("ce_rd",    32'(rd_ex), 32'h9);
      chk("ce_imm",   imm_ex, 32'h0);
      chk("ce_src2",  32'(alu_src2_ex), 32'h0);
      clk_en = 1'b1; reg_wr_wb = 1'b0;
      inst_id.raw = 32'h00058633; // add x12,x11,x0
      tick();
      chk("ce_x11",   rs1_data_ex, 32'h0);
      chk("ce_rd12",  32'(rd_ex), 32'hC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Consumes the registered instruction and PC from the IF/ID register and decodes the RV32I opcode.
- Generates the sign-extended immediate and reads the 32x32 register file.
- Detects load-use hazards and registers everything into the ID/EX pipeline register for the execute stage. Write-back from the last stage enters here through the register-file write port.

Parameters:
- XLEN, 32, datapath width; must match dataBus_t.
- NREGS, 32, architectural register count; x0 is hard-wired to zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  clock enable, shared with the fetch stage
- inst_id  in  32 (instruction_u)  instruction to decode, from IF/ID
- pc_id  in  32 (dataBus_t)  PC of inst_id
- flush  in  1  replace the ID/EX contents with a bubble
- reg_wr_wb  in  1  write-back enable
- rd_wb  in  5  write-back destination register
- rd_data_wb  in  32  write-back data
- stall_id  out  1  load-use stall; top level holds fetch and IF/ID while it is high
- pc_ex  out  32  registered PC
- rs1_data_ex, rs2_data_ex  out  32 each  registered operands
- imm_ex  out  32  registered sign-extended immediate
- rs1_ex, rs2_ex, rd_ex  out  5 each  registered register addresses, used for forwarding
- funct3_ex  out  3  registered funct3
- alu_op_ex  out  4 (aluOp_e)  ALU operation
- alu_src1_ex  out  1  0 = rs1, 1 = PC
- alu_src2_ex  out  1  0 = rs2, 1 = imm
- mem_rd_ex, mem_wr_ex, reg_wr_ex  out  1 each  memory read, memory write, register write enables
- wb_sel_ex  out  2 (wbSel_e)  write-back source: ALU, MEM, PC+4
- branch_ex, jump_ex  out  1 each  conditional branch; JAL/JALR
- trap_ex  out  1  illegal instruction, ECALL or EBREAK

Behaviour:
- Reset: rst_n low clears every *_ex output, stall_id and all registers x1..x31 to 0, asynchronously.
- Latency: 1 cycle. ID/EX updates on the rising edge only when clk_en is 1; with clk_en at 0 all state holds, including regfile writes.
- ID/EX priority: rst_n, then flush, then stall_id, then normal load.
  - flush and stall_id both load a bubble: all control bits 0, data fields 0.
  - flush does not gate regfile writes.
- stall_id is combinational. It is 1 when all of the following hold:
  - mem_rd_ex is 1 and rd_ex is not 0;
  - rd_ex equals rs1 of inst_id and the format uses rs1 (R/I/S/B, JALR), or rd_ex equals rs2 and the format uses rs2 (R/S/B).
  - flush forces stall_id to 0.
- Register file:
  - Write: on the clock edge when clk_en=1, reg_wr_wb=1 and rd_wb is not 0.
  - Reads are combinational; x0 always reads 0.
  - Write-through: if rd_wb matches a read address in the same cycle (and is not 0, with reg_wr_wb=1), the read returns rd_data_wb.
- Immediate generation, always sign-extended from inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type: imm = 0.
- Opcode decode:
  - LUI: alu COPY2, src2=imm.
  - AUIPC: src1=PC, src2=imm, ADD.
  - JAL and JALR: jump=1, reg_wr=1, wb=PC4. JAL uses src1=PC; JALR uses src1=rs1. Both use src2=imm, ADD.
  - BRANCH: branch=1, alu SUB/compare chosen by funct3; funct3 010 and 011 are illegal.
  - LOAD: mem_rd=1, reg_wr=1, wb=MEM, ADD with imm.
  - STORE: mem_wr=1, ADD with imm.
  - OP-IMM and OP: ALU op from funct3 plus funct7[5] (SUB only for OP, SRA for both).
  - MISC-MEM (FENCE): NOP.
  - SYSTEM with imm 0 or 1: trap=1.
- Illegal instructions: unknown opcode or invalid funct7 set trap_ex=1 and clear every write enable.
- inst_id = 32'h0 (fetch flush bubble) decodes as a NOP with trap_ex=0. This is the only exception to the illegal rule.
- rd_ex is forced to 0 when the instruction does not write a register (S/B types), so forwarding logic never matches.

Decomposition:
- riscv_definitions gains:
  - aluOp_e: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY2
  - wbSel_e: WB_ALU, WB_MEM, WB_PC4
  - opcode_e localparams for the 11 RV32I opcodes
  - regAddr_t (5 bits)
- Sub-module register_file:
  - 2 read ports, 1 write port, asynchronous reset, x0 fixed at zero, write-through.
  - Instantiated once; verified standalone as well.

Test Plan:
- Reset, then inst_id=32'h00500093 (addi x1,x0,5) -> next cycle: reg_wr_ex=1, rd_ex=1, imm_ex=5, alu_op_ex=ADD, alu_src2_ex=1, trap_ex=0.
- Write-back reg_wr_wb=1, rd_wb=2, rd_data_wb=32'hDEADBEEF, same cycle inst_id=add x3,x2,x2 -> rs1_data_ex = rs2_data_ex = 32'hDEADBEEF (write-through).
- ID/EX holds lw x5 (mem_rd_ex=1, rd_ex=5) and inst_id=add x6,x5,x1 -> stall_id=1 and ID/EX gets a bubble. Next cycle, with mem_rd_ex=0, the add is issued.
- inst_id=32'hFE000EE3 (beq x0,x0,-4) -> branch_ex=1, imm_ex=32'hFFFFFFFC, rd_ex=0, reg_wr_ex=0.
- flush=1 with a valid instruction -> all ID/EX control bits 0.
- inst_id=32'h0 -> NOP with trap_ex=0.
- inst_id=32'hFFFFFFFF -> trap_ex=1, all write enables 0.
- Write to x0 with 32'h1234 -> subsequent read of x0 returns 0.
- clk_en=0 for 3 cycles during a regfile write -> outputs and registers unchanged.
